// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and sync-window helper; also imported by
// the colour mapper so both agree on the visible area.
package vga_pkg;

    localparam int COORD_W   = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Half-open window test: lo <= v < hi
    function automatic logic in_window(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_ce_gen.sv
// Clock divider producing a one-cycle pixel clock-enable every CLK_DIV clocks.
module pixel_ce_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic srst,
    output logic pixel_ce
);

    // Keep at least one bit so CLK_DIV==1 still elaborates.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt_reg;
    logic          pixel_ce_reg;
    logic          div_last;

    assign div_last = (div_cnt_reg == DW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (srst) begin
            div_cnt_reg  <= '0;
            pixel_ce_reg <= 1'b0;
        end else begin
            pixel_ce_reg <= div_last;
            div_cnt_reg  <= div_last ? '0 : div_cnt_reg + 1'b1;
        end
    end

    assign pixel_ce = pixel_ce_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/blank decode and line/frame strobes for the VGA path.
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start
);

    import vga_pkg::*;

    localparam int H_TOT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic       pixel_ce_int;
    logic [9:0] x_reg, x_next;
    logic [9:0] y_reg, y_next;
    logic       hs_reg, vs_reg, blank_reg;
    logic       line_start_reg, frame_start_reg;
    logic       x_wrap, y_wrap;

    pixel_ce_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_ce_gen (
        .clk      (Clk),
        .srst     (Reset),
        .pixel_ce (pixel_ce_int)
    );

    assign x_wrap = (x_reg == 10'(H_TOT - 1));
    assign y_wrap = (y_reg == 10'(V_TOT - 1));

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (pixel_ce_int) begin
            if (x_wrap) begin
                x_next = '0;
                y_next = y_wrap ? '0 : y_reg + 10'd1;
            end else begin
                x_next = x_reg + 10'd1;
            end
        end
    end

    // Decode from the next counter values so sync/blank line up with DrawX/DrawY.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_reg           <= '0;
            y_reg           <= '0;
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            blank_reg       <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            line_start_reg  <= pixel_ce_int && x_wrap;
            frame_start_reg <= pixel_ce_int && x_wrap && y_wrap;
            if (pixel_ce_int) begin
                x_reg     <= x_next;
                y_reg     <= y_next;
                hs_reg    <= !in_window(int'(x_next), HS_START, HS_END);
                vs_reg    <= !in_window(int'(y_next), VS_START, VS_END);
                blank_reg <= (int'(x_next) < H_VISIBLE) && (int'(y_next) < V_VISIBLE);
            end
        end
    end

    assign pixel_ce    = pixel_ce_int;
    assign DrawX       = x_reg;
    assign DrawY       = y_reg;
    assign hs          = hs_reg;
    assign vs          = vs_reg;
    assign blank       = blank_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: three raster instances (full 640x480, small CLK_DIV=2, small CLK_DIV=1)
// checked every cycle against a closed-form position model plus scenario checks.
module tb_vga_timing_gen;

    localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3;   // 25 px per line
    localparam int SVV = 8,  SVF = 2, SVS = 2, SVB = 3;   // 15 lines per frame

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic       f_ce, f_hs, f_vs, f_bl, f_ls, f_fs;
    logic [9:0] f_x, f_y;
    logic       s_ce, s_hs, s_vs, s_bl, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic       d_ce, d_hs, d_vs, d_bl, d_ls, d_fs;
    logic [9:0] d_x, d_y;

    vga_timing_gen dut_full (
        .Clk(Clk), .Reset(Reset), .pixel_ce(f_ce), .DrawX(f_x), .DrawY(f_y),
        .hs(f_hs), .vs(f_vs), .blank(f_bl), .line_start(f_ls), .frame_start(f_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) dut_small (
        .Clk(Clk), .Reset(Reset), .pixel_ce(s_ce), .DrawX(s_x), .DrawY(s_y),
        .hs(s_hs), .vs(s_vs), .blank(s_bl), .line_start(s_ls), .frame_start(s_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) dut_div1 (
        .Clk(Clk), .Reset(Reset), .pixel_ce(d_ce), .DrawX(d_x), .DrawY(d_y),
        .hs(d_hs), .vs(d_vs), .blank(d_bl), .line_start(d_ls), .frame_start(d_fs)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_cnt = 0;   // Clk edges since Reset was last sampled low

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int ce, x, y, hs, vs, bl, ls, fs;
    } exp_t;

    // After n edges out of reset, floor((n-1)/d) pixels have elapsed; every
    // output follows from that raster position.
    function automatic exp_t model(input int n, input int d,
                                   input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb);
        exp_t r;
        int ht, vt, adv, p;
        bit stepped;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        r = '{0, 0, 0, 1, 1, 0, 0, 0};
        if (n > 0) begin
            r.ce = (n % d == 0) ? 1 : 0;
            adv  = (n - 1) / d;
            p    = adv % (ht * vt);
            r.x  = p % ht;
            r.y  = p / ht;
            if (adv > 0) begin
                r.hs = (r.x >= hv + hf && r.x < hv + hf + hsw) ? 0 : 1;
                r.vs = (r.y >= vv + vf && r.y < vv + vf + vsw) ? 0 : 1;
                r.bl = (r.x < hv && r.y < vv) ? 1 : 0;
            end
            stepped = (n >= 2) && ((n - 1) % d == 0);
            r.ls = (stepped && r.x == 0) ? 1 : 0;
            r.fs = (stepped && r.x == 0 && r.y == 0) ? 1 : 0;
        end
        return r;
    endfunction

    task automatic check_set(input string nm, input exp_t e,
                             input int ce, input int x, input int y, input int hs_v,
                             input int vs_v, input int bl, input int ls, input int fs);
        check({nm, ".pixel_ce"},    ce,   e.ce);
        check({nm, ".DrawX"},       x,    e.x);
        check({nm, ".DrawY"},       y,    e.y);
        check({nm, ".hs"},          hs_v, e.hs);
        check({nm, ".vs"},          vs_v, e.vs);
        check({nm, ".blank"},       bl,   e.bl);
        check({nm, ".line_start"},  ls,   e.ls);
        check({nm, ".frame_start"}, fs,   e.fs);
    endtask

    always @(posedge Clk) n_cnt <= Reset ? 0 : n_cnt + 1;

    always @(negedge Clk) begin
        check_set("full", model(n_cnt, 2, 640, 16, 96, 48, 480, 10, 2, 33),
                  f_ce, f_x, f_y, f_hs, f_vs, f_bl, f_ls, f_fs);
        check_set("small", model(n_cnt, 2, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB),
                  s_ce, s_x, s_y, s_hs, s_vs, s_bl, s_ls, s_fs);
        check_set("div1", model(n_cnt, 1, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB),
                  d_ce, d_x, d_y, d_hs, d_vs, d_bl, d_ls, d_fs);
    end

    initial begin
        int cnt, hs_low, blank_fall, ls_seen, ls_x, ls_y;
        int fs_cnt, fs_n, bl_cnt, vs_cnt, vs_min, vs_max, c0;
        bit prev_bl;

        // Reset held 3 cycles, then time to first pixel_ce
        repeat (3) @(negedge Clk);
        check("rst.DrawX", f_x, 0);
        check("rst.hs", f_hs, 1);
        check("rst.blank", f_bl, 0);
        Reset = 1'b0;
        cnt = 0;
        do begin
            @(negedge Clk);
            cnt++;
        end while (!f_ce && cnt < 10);
        check("ce_first_latency", cnt, 2);

        // One full 800-pixel line on the default-size instance
        hs_low = 0; blank_fall = -1; ls_seen = 0; ls_x = -1; ls_y = -1; prev_bl = 1'b0;
        while (n_cnt < 1605) begin
            @(negedge Clk);
            if (f_ce && !f_hs) hs_low++;
            if (prev_bl && !f_bl && blank_fall < 0) blank_fall = int'(f_x);
            prev_bl = f_bl;
            if (f_ls && ls_seen == 0) begin
                ls_seen = 1; ls_x = int'(f_x); ls_y = int'(f_y);
            end
        end
        check("line.hs_low_pixels", hs_low, 96);
        check("line.blank_fall_x", blank_fall, 640);
        check("line.ls_seen", ls_seen, 1);
        check("line.ls_x", ls_x, 0);
        check("line.ls_y", ls_y, 1);

        // Two small frames: strobe count, boundary, vsync lines, visible pixels
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        fs_cnt = 0; fs_n = -1; bl_cnt = 0; vs_cnt = 0; vs_min = 999; vs_max = -1;
        while (n_cnt < 1501) begin
            @(negedge Clk);
            if (s_fs && n_cnt <= 751) begin
                fs_cnt++;
                if (fs_n < 0) begin
                    fs_n = n_cnt;
                    check("wrap.line_start", s_ls, 1);
                    check("wrap.hs", s_hs, 1);
                    check("wrap.vs", s_vs, 1);
                    check("wrap.blank", s_bl, 1);
                    check("wrap.xy", int'(s_x) + int'(s_y), 0);
                end
            end
            if (n_cnt >= 752 && s_ce) begin
                if (s_bl) bl_cnt++;
                if (!s_vs) begin
                    vs_cnt++;
                    if (int'(s_y) < vs_min) vs_min = int'(s_y);
                    if (int'(s_y) > vs_max) vs_max = int'(s_y);
                end
            end
        end
        check("frame.fs_count", fs_cnt, 1);
        check("frame.fs_cycle", fs_n, 751);
        check("frame.visible_pixels", bl_cnt, SHV * SVV);
        check("frame.vs_low_pixels", vs_cnt, SVS * 25);
        check("frame.vs_min_y", vs_min, SVV + SVF);
        check("frame.vs_max_y", vs_max, SVV + SVF + SVS - 1);

        // Line period of the CLK_DIV=1 instance
        cnt = 0;
        while (!d_ls && cnt < 100) begin @(negedge Clk); cnt++; end
        c0 = 0;
        do begin @(negedge Clk); c0++; end while (!d_ls && c0 < 100);
        check("div1.line_period", c0, 25);

        // Mid-frame reset, then a full frame before the next frame_start
        cnt = 0;
        while (!(s_x == 10'd7 && s_y == 10'd5) && cnt < 1000) begin @(negedge Clk); cnt++; end
        check("midrst.reached", (s_x == 10'd7 && s_y == 10'd5) ? 1 : 0, 1);
        Reset = 1'b1;
        @(negedge Clk);
        check("midrst.x", s_x, 0);
        check("midrst.y", s_y, 0);
        check("midrst.hs_vs", {30'd0, s_hs, s_vs}, 3);
        check("midrst.blank", s_bl, 0);
        Reset = 1'b0;
        cnt = 0;
        do begin @(negedge Clk); cnt++; end while (!s_fs && cnt < 2000);
        check("midrst.next_fs", cnt, 751);

        // Random run lengths and reset pulses, checked by the per-cycle model
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(50, 900)) @(negedge Clk);
            Reset = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge Clk);
            Reset = 1'b0;
        end
        repeat (400) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
